wb_regfile: RTL and testbench

Writeback stage and general-purpose register file of the 5-stage pipeline. Sits directly downstream of the MEM/WB pipeline register and consumes its `wwreg`, `wm2reg`, `wmo`, `walu` and `wGPR` outputs. Selects the writeback value, commits it to a 32-entry register file on the clock edge, and serves the two ID-stage read ports with internal write-to-read bypass. Exposes the selected writeback value for EX-stage forwarding.

---
 rtl/wb_regfile_if.sv | 29 ++
 rtl/wb_regfile.sv | 88 ++++++++
 tb/tb_wb_regfile.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Writeback / register-file bus: MEM/WB writeback fields, ID read ports,
// and the forwarding/activity outputs. The pipeline side is the master,
// the register file is the slave.
interface wb_regfile_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          wwreg;
    logic          wm2reg;
    logic [DW-1:0] wmo;
    logic [DW-1:0] walu;
    logic [AW-1:0] wGPR;
    logic [AW-1:0] rna;
    logic [AW-1:0] rnb;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic [DW-1:0] wdi;
    logic          wact;

    modport master (
        output wwreg, wm2reg, wmo, walu, wGPR, rna, rnb,
        input  qa, qb, wdi, wact
    );

    modport slave (
        input  wwreg, wm2reg, wmo, walu, wGPR, rna, rnb,
        output qa, qb, wdi, wact
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage plus 2^AW-entry general-purpose register file.
// Selects the writeback value (ALU or memory), commits it on the rising
// clock edge, and serves two combinational read ports that bypass the
// value being written this cycle. Register 0 is hardwired to zero.
module wb_regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] regs_q [DEPTH];
    logic [DW-1:0] regs_d [DEPTH];
    logic          wact_q;
    logic          wact_d;
    logic [DW-1:0] wdi_s;
    logic          wr_en_s;
    logic [DW-1:0] qa_s;
    logic [DW-1:0] qb_s;

    // One read port: r0 and reset read zero, a matching write is bypassed,
    // otherwise the stored entry is returned.
    function automatic logic [DW-1:0] read_port(
        input logic          rst_n_v,
        input logic [AW-1:0] idx,
        input logic          wr_en_v,
        input logic [AW-1:0] widx,
        input logic [DW-1:0] wdata,
        input logic [DW-1:0] stored
    );
        logic [DW-1:0] val;
        if (!rst_n_v || (idx == '0)) begin
            val = '0;
        end else if (wr_en_v && (widx == idx)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Writeback source select and commit qualifier (r0 is never written).
    always_comb begin
        wdi_s   = bus.wm2reg ? bus.wmo : bus.walu;
        wr_en_s = bus.wwreg && (bus.wGPR != '0);
    end

    // Next-state of the register array and the write-activity flag.
    always_comb begin
        regs_d = regs_q;
        if (wr_en_s) begin
            regs_d[bus.wGPR] = wdi_s;
        end else begin
            regs_d[bus.wGPR] = regs_q[bus.wGPR];
        end
        regs_d[0] = '0;
        wact_d    = wr_en_s;
    end

    // State registers; asynchronous reset clears every entry and the flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            wact_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wact_q <= wact_d;
        end
    end

    // Combinational read ports with write-to-read bypass.
    always_comb begin
        qa_s = read_port(rst, bus.rna, wr_en_s, bus.wGPR, wdi_s, regs_q[bus.rna]);
        qb_s = read_port(rst, bus.rnb, wr_en_s, bus.wGPR, wdi_s, regs_q[bus.rnb]);
    end

    assign bus.qa   = qa_s;
    assign bus.qb   = qb_s;
    assign bus.wdi  = wdi_s;
    assign bus.wact = wact_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile with an expected-value scoreboard.
module tb_wb_regfile;
    localparam int DW = 32;
    localparam int AW = 5;

    localparam int unsigned SEL_QA   = 0;
    localparam int unsigned SEL_QB   = 1;
    localparam int unsigned SEL_WDI  = 2;
    localparam int unsigned SEL_WACT = 3;

    typedef struct {
        string       tag;
        int unsigned sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    exp_t sb_q[$];

    wb_regfile_if #(.DW(DW), .AW(AW)) bus ();

    wb_regfile #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input int unsigned sel, input logic [31:0] e);
        exp_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = e;
        sb_q.push_back(it);
    endtask

    // Let combinational paths settle, then compare every queued expectation.
    task automatic drain();
        exp_t        it;
        logic [31:0] obs;
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            case (it.sel)
                SEL_QA:   obs = bus.qa;
                SEL_QB:   obs = bus.qb;
                SEL_WDI:  obs = bus.wdi;
                SEL_WACT: obs = {31'b0, bus.wact};
                default:  obs = 'x;
            endcase
            tests++;
            assert (obs === it.exp) else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] mo,
                         input logic [31:0] alu, input logic [4:0] dst,
                         input logic [4:0] ra, input logic [4:0] rb);
        bus.wwreg  = we;
        bus.wm2reg = m2r;
        bus.wmo    = mo;
        bus.walu   = alu;
        bus.wGPR   = dst;
        bus.rna    = ra;
        bus.rnb    = rb;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

        // Reset state
        expect_val("rst_qa", SEL_QA, 32'h0);
        expect_val("rst_qb", SEL_QB, 32'h0);
        expect_val("rst_wact", SEL_WACT, 32'h0);
        drain();

        // Write attempted while in reset: bypass suppressed, no commit
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0099, 5'd4, 5'd4, 5'd4);
        expect_val("rst_bypass_qa", SEL_QA, 32'h0);
        expect_val("rst_wdi", SEL_WDI, 32'h0000_0099);
        drain();
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
        rst = 1'b1;
        expect_val("rst_nowrite_r4", SEL_QA, 32'h0);
        drain();

        // Preload r5, bypass then stored
        drive(1'b1, 1'b0, 32'h0, 32'h1234_5678, 5'd5, 5'd5, 5'd0);
        expect_val("pre_r5_bypass", SEL_QA, 32'h1234_5678);
        drain();
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        expect_val("pre_r5_stored", SEL_QA, 32'h1234_5678);
        expect_val("pre_wact", SEL_WACT, 32'h1);
        drain();

        // Async reset pulse between edges
        rst = 1'b0;
        expect_val("pulse_qa", SEL_QA, 32'h0);
        expect_val("pulse_wact", SEL_WACT, 32'h0);
        drain();
        rst = 1'b1;
        expect_val("post_rst_r5", SEL_QA, 32'h0);
        drain();
        tick();
        expect_val("post_rst_wact", SEL_WACT, 32'h0);
        expect_val("post_rst_r5_b", SEL_QA, 32'h0);
        drain();

        // ALU writeback
        drive(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 5'd3, 5'd3, 5'd0);
        expect_val("alu_bypass", SEL_QA, 32'hDEAD_BEEF);
        expect_val("alu_wdi", SEL_WDI, 32'hDEAD_BEEF);
        drain();
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd0);
        expect_val("alu_stored", SEL_QA, 32'hDEAD_BEEF);
        expect_val("alu_wact1", SEL_WACT, 32'h1);
        drain();
        tick();
        expect_val("alu_wact0", SEL_WACT, 32'h0);
        drain();

        // Memory writeback to r31
        drive(1'b1, 1'b1, 32'h0000_00FF, 32'h1111_1111, 5'd31, 5'd0, 5'd31);
        expect_val("mem_wdi", SEL_WDI, 32'h0000_00FF);
        expect_val("mem_bypass", SEL_QB, 32'h0000_00FF);
        drain();
        tick();
        drive(1'b0, 1'b0, 32'h0000_00FF, 32'h1111_1111, 5'd31, 5'd0, 5'd31);
        expect_val("mem_stored", SEL_QB, 32'h0000_00FF);
        expect_val("mem_wact", SEL_WACT, 32'h1);
        expect_val("alu_sel_wdi", SEL_WDI, 32'h1111_1111);
        drain();

        // r0 protection
        drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        expect_val("r0_qa_pre", SEL_QA, 32'h0);
        expect_val("r0_qb_pre", SEL_QB, 32'h0);
        drain();
        tick();
        expect_val("r0_qa_post", SEL_QA, 32'h0);
        expect_val("r0_qb_post", SEL_QB, 32'h0);
        expect_val("r0_wact", SEL_WACT, 32'h0);
        drain();

        // Write disabled: r7 = 5, then a disabled write of 0xAAAAAAAA
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0005, 5'd7, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'hAAAA_AAAA, 5'd7, 5'd0, 5'd7);
        expect_val("wdis_qb_pre", SEL_QB, 32'h0000_0005);
        drain();
        tick();
        expect_val("wdis_qb_post", SEL_QB, 32'h0000_0005);
        expect_val("wdis_wact", SEL_WACT, 32'h0);
        drain();

        // Dual-port same index: r8 = 0x77, r9 = 0x10, then write 0x20 to r9
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0077, 5'd8, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0010, 5'd9, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0020, 5'd9, 5'd9, 5'd9);
        expect_val("dual_qa", SEL_QA, 32'h0000_0020);
        expect_val("dual_qb", SEL_QB, 32'h0000_0020);
        drain();
        bus.rna = 5'd8;
        expect_val("dual_r8_qa", SEL_QA, 32'h0000_0077);
        expect_val("dual_r9_qb", SEL_QB, 32'h0000_0020);
        drain();
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd8);
        expect_val("dual_r9_stored", SEL_QA, 32'h0000_0020);
        expect_val("dual_r8_stored", SEL_QB, 32'h0000_0077);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
